bbox_finder: RTL and testbench
==============================

# bbox_finder

Scans a stored RGB image once per `start`, thresholds each pixel's summed channels and reports the inclusive bounding box of all foreground (dark) pixels. It sits directly upstream of the cropping stage. It reads the same frame buffer with the same column-major, 3-bytes-per-pixel layout, and its `xMin/xMax/yMin/yMax` outputs drive the cropper's bound inputs.

## Interface
- `WIDTH`, 100: image width in pixels.
- `HEIGHT`, 100: image height in pixels.
- `THRESH`, 128: per-channel darkness threshold. A pixel is foreground when r+g+b < 3*THRESH.
- `MARGIN`, 2: box expansion in pixels; used only when `BBOX_MARGIN_EN` is defined.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: begin a scan. Sampled in IDLE and DONE only.
- `done`  out  1: high while in DONE.
- `found`  out  1: at least one foreground pixel in the last completed scan.
- `readAddr`  out  24: frame-buffer byte address.
- `readdata`  in  16: memory data. Only bits [7:0] are used. Valid one cycle after `readAddr`.
- `xMin`, `xMax`, `yMin`, `yMax`  out  11 each: inclusive box of the last completed scan.

## Operation
- The scan order is x outer, y inner, channel c innermost (0..2).
- `readAddr` = x*HEIGHT*3 + y*3 + c. It is computed combinationally from the registered counters, in 24-bit arithmetic.
- States:
  - IDLE: on `start`, go to READ.
  - READ: `readAddr` is presented. Go to CAPT.
  - CAPT: add `readdata[7:0]` to the 10-bit `sum`. If c<2, increment c and go to READ. Otherwise go to EVAL.
  - EVAL: if `sum` < 3*THRESH, update the running minimum/maximum of x and y and set the running found flag. Clear `sum` and c. Advance y; when y wraps from HEIGHT-1, advance x. After the pixel (WIDTH-1, HEIGHT-1), go to LATCH. Otherwise go to READ.
  - LATCH: copy the running box and flag to the outputs. Go to DONE.
  - DONE: `done`=1. On `start`, clear the running registers and go to READ.
- Running registers are cleared at scan start: minimum = 11'h7FF, maximum = 0, found flag = 0.
- If no foreground pixel is found, the outputs are `found`=0 and the full frame: 0, WIDTH-1, 0, HEIGHT-1.
- Outputs change only in LATCH. They hold the previous result for the whole duration of a new scan.
- `start` during READ, CAPT or EVAL is ignored.
- `readdata[15:8]` is ignored.
- Constraint: 3*WIDTH*HEIGHT ≤ 2^24, and WIDTH, HEIGHT ≤ 2047.

## Timing
- Reset values:
  - `done`=0, `found`=0, `readAddr`=0.
  - `xMin`=0, `xMax`=WIDTH-1, `yMin`=0, `yMax`=HEIGHT-1.
  - State = IDLE; counters and `sum` = 0.
- Each pixel takes 7 cycles (READ/CAPT ×3, then EVAL).
- `start` sampled at cycle 0 puts READ of pixel (0,0) ch0 at cycle 1.
- The last EVAL is at cycle 7*W*H and LATCH at 7*W*H+1.
- `done` rises at cycle 7*W*H+2 and stays high until `start` or `rst`.
- Memory read latency is exactly 1 cycle. `readAddr` is stable throughout READ and CAPT.
- `rst` mid-scan: on the next edge, go to IDLE and restore all outputs to their reset values. The partial scan is discarded.
- `start` and `rst` in the same cycle: `rst` wins.

## Configuration
- `BBOX_MARGIN_EN` defined: in LATCH, the box expands by MARGIN on each side, clamped to the image.
  - `xMin` = max(0, min-MARGIN); `xMax` = min(WIDTH-1, max+MARGIN); likewise for y.
  - Expansion applies only when the found flag is 1.
  - The subtraction is done in signed 12-bit to avoid underflow.
- `BBOX_MARGIN_EN` undefined: the exact box is reported and MARGIN is unused.

## Structure
- `bbox_pkg` holds the state enum (IDLE, READ, CAPT, EVAL, LATCH, DONE), `COORD_W`=11 and `ADDR_W`=24.
- Sub-module `bbox_tracker`: the running min/max/found registers, with clear, update-enable and x/y inputs. It is instantiated once. The FSM, counters and address generator stay in `bbox_finder`.

## Test plan
- Reset, idle 10 cycles: `done`=0, `found`=0, box = 0/99/0/99, `readAddr`=0.
- All bytes 255, `start` pulse: `done` rises at cycle 70002; `found`=0; box 0/99/0/99.
- White image with pixel (37,52)=(10,10,10): `found`=1, `xMin`=`xMax`=37, `yMin`=`yMax`=52.
- Threshold edge: pixel (5,5) sum=384 gives `found`=0. Repeat with sum=383: `found`=1, box 5/5/5/5.
- Dark pixel at (60,60); assert `rst` at cycle 30000; wait 5 cycles; `start`:
  - Outputs return to reset values immediately after `rst`.
  - The fresh scan completes with box 60/60/60/60.
- Single dark pixel (1,98):
  - With `BBOX_MARGIN_EN`, MARGIN=2: box x 0..3, y 96..99 (clamped).
  - Without the macro: box 1..1, 98..98.

Source files
------------

// File: rtl/bbox_pkg.sv
// Shared types and widths for the bounding-box finder.
package bbox_pkg;
  localparam int COORD_W = 11;
  localparam int ADDR_W  = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CAPT  = 3'd2,
    EVAL  = 3'd3,
    LATCH = 3'd4,
    DONE  = 3'd5
  } state_t;
endpackage

// File: rtl/bbox_tracker.sv
// Running min/max of foreground coordinates plus a sticky found flag.
module bbox_tracker
  import bbox_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_update,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic [COORD_W-1:0] o_min_x,
  output logic [COORD_W-1:0] o_max_x,
  output logic [COORD_W-1:0] o_min_y,
  output logic [COORD_W-1:0] o_max_y,
  output logic               o_found
);
  logic [COORD_W-1:0] r_min_x, r_max_x, r_min_y, r_max_y;
  logic               r_found;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_min_x <= '1;
      r_min_y <= '1;
      r_max_x <= '0;
      r_max_y <= '0;
      r_found <= 1'b0;
    end else if (i_update) begin
      if (i_x < r_min_x) r_min_x <= i_x;
      if (i_x > r_max_x) r_max_x <= i_x;
      if (i_y < r_min_y) r_min_y <= i_y;
      if (i_y > r_max_y) r_max_y <= i_y;
      r_found <= 1'b1;
    end
  end

  assign o_min_x = r_min_x;
  assign o_max_x = r_max_x;
  assign o_min_y = r_min_y;
  assign o_max_y = r_max_y;
  assign o_found = r_found;
endmodule

// File: rtl/bbox_finder.sv
// Scans a column-major RGB frame and reports the inclusive box of dark pixels.
// Define BBOX_MARGIN_EN to grow the reported box by MARGIN, clamped to the image.
module bbox_finder
  import bbox_pkg::*;
#(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100,
  parameter int THRESH = 128,
  parameter int MARGIN = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               done,
  output logic               found,
  output logic [ADDR_W-1:0]  readAddr,
  input  logic [15:0]        readdata,
  output logic [COORD_W-1:0] xMin,
  output logic [COORD_W-1:0] xMax,
  output logic [COORD_W-1:0] yMin,
  output logic [COORD_W-1:0] yMax,
  output logic [2:0]         o_dbg_state
);
  state_t             r_state;
  logic [COORD_W-1:0] r_x, r_y;
  logic [1:0]         r_c;
  logic [9:0]         r_sum;
  logic               r_done, r_found;
  logic [COORD_W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;

  logic               w_fg, w_clear, w_update, w_run_found, w_unused_hi;
  logic [COORD_W-1:0] w_min_x, w_max_x, w_min_y, w_max_y;
  logic [COORD_W-1:0] w_lat_xmin, w_lat_xmax, w_lat_ymin, w_lat_ymax;

  assign w_unused_hi = ^readdata[15:8];
  assign readAddr = ADDR_W'(r_x) * ADDR_W'(HEIGHT * 3) + ADDR_W'(r_y) * ADDR_W'(3) + ADDR_W'(r_c);
  assign w_fg     = int'(r_sum) < 3 * THRESH;
  assign w_clear  = start && (r_state == IDLE || r_state == DONE);
  assign w_update = (r_state == EVAL) && w_fg;

  bbox_tracker u_tracker (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_update (w_update),
    .i_x      (r_x),
    .i_y      (r_y),
    .o_min_x  (w_min_x),
    .o_max_x  (w_max_x),
    .o_min_y  (w_min_y),
    .o_max_y  (w_max_y),
    .o_found  (w_run_found)
  );

`ifdef BBOX_MARGIN_EN
  // Low side in signed arithmetic so min-MARGIN can go negative before clamping.
  logic signed [11:0] w_xlo, w_ylo;
  logic        [11:0] w_xhi, w_yhi;
  assign w_xlo = $signed({1'b0, w_min_x}) - $signed(12'(MARGIN));
  assign w_ylo = $signed({1'b0, w_min_y}) - $signed(12'(MARGIN));
  assign w_xhi = {1'b0, w_max_x} + 12'(MARGIN);
  assign w_yhi = {1'b0, w_max_y} + 12'(MARGIN);
  assign w_lat_xmin = (w_xlo < 0) ? '0 : w_xlo[COORD_W-1:0];
  assign w_lat_ymin = (w_ylo < 0) ? '0 : w_ylo[COORD_W-1:0];
  assign w_lat_xmax = (w_xhi > 12'(WIDTH - 1))  ? COORD_W'(WIDTH - 1)  : w_xhi[COORD_W-1:0];
  assign w_lat_ymax = (w_yhi > 12'(HEIGHT - 1)) ? COORD_W'(HEIGHT - 1) : w_yhi[COORD_W-1:0];
`else
  localparam int margin_unused = MARGIN;
  assign w_lat_xmin = w_min_x;
  assign w_lat_xmax = w_max_x;
  assign w_lat_ymin = w_min_y;
  assign w_lat_ymax = w_max_y;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_c     <= '0;
      r_sum   <= '0;
      r_done  <= 1'b0;
      r_found <= 1'b0;
      r_xmin  <= '0;
      r_xmax  <= COORD_W'(WIDTH - 1);
      r_ymin  <= '0;
      r_ymax  <= COORD_W'(HEIGHT - 1);
    end else begin
      case (r_state)
        IDLE: if (start) r_state <= READ;
        READ: r_state <= CAPT;
        CAPT: begin
          r_sum <= r_sum + {2'b00, readdata[7:0]};
          if (r_c < 2'd2) begin
            r_c     <= r_c + 2'd1;
            r_state <= READ;
          end else begin
            r_state <= EVAL;
          end
        end
        EVAL: begin
          r_sum   <= '0;
          r_c     <= '0;
          r_state <= READ;
          if (r_y == COORD_W'(HEIGHT - 1)) begin
            r_y <= '0;
            if (r_x == COORD_W'(WIDTH - 1)) begin
              r_x     <= '0;
              r_state <= LATCH;
            end else begin
              r_x <= r_x + 1'b1;
            end
          end else begin
            r_y <= r_y + 1'b1;
          end
        end
        LATCH: begin
          r_found <= w_run_found;
          if (w_run_found) begin
            r_xmin <= w_lat_xmin;
            r_xmax <= w_lat_xmax;
            r_ymin <= w_lat_ymin;
            r_ymax <= w_lat_ymax;
          end else begin
            r_xmin <= '0;
            r_xmax <= COORD_W'(WIDTH - 1);
            r_ymin <= '0;
            r_ymax <= COORD_W'(HEIGHT - 1);
          end
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: if (start) begin
          r_done  <= 1'b0;
          r_state <= READ;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign done        = r_done;
  assign found       = r_found;
  assign xMin        = r_xmin;
  assign xMax        = r_xmax;
  assign yMin        = r_ymin;
  assign yMax        = r_ymax;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_bbox_finder.sv
// Directed bench for bbox_finder on a small 12x10 frame; honours BBOX_MARGIN_EN.
module tb_bbox_finder;
  localparam int TW    = 12;
  localparam int TH    = 10;
  localparam int MG    = 2;
  localparam int MEMN  = 3 * TW * TH;
  localparam int LAT   = 7 * TW * TH + 2;
  localparam int LIMIT = LAT + 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        done, found;
  logic [23:0] readAddr;
  logic [15:0] readdata = '0;
  logic [10:0] xMin, xMax, yMin, yMax;
  logic [2:0]  dbg_state;

  logic [7:0]  mem [0:MEMN-1];
  logic [44:0] exp_q [$];
  logic [44:0] last_res, exp_res;
  int          total = 0;
  int          bad = 0;
  int          lat;
  logic [23:0] a1, a3, a87, a88;
  logic [44:0] mid_res;

  bbox_finder #(.WIDTH(TW), .HEIGHT(TH), .THRESH(128), .MARGIN(MG)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .found(found),
    .readAddr(readAddr), .readdata(readdata),
    .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax), .o_dbg_state(dbg_state)
  );

  // clock and one-cycle-latency frame buffer; upper byte is random junk
  always #5 clk = ~clk;
  always @(posedge clk)
    readdata <= {8'($urandom), (int'(readAddr) < MEMN) ? mem[readAddr] : 8'hFF};

  function automatic logic [44:0] cur_res();
    return {found, xMin, xMax, yMin, yMax};
  endfunction

  function automatic logic [44:0] exp_box(input bit f, input int x0, input int x1,
                                          input int y0, input int y1);
    if (!f) return {1'b0, 11'd0, 11'(TW - 1), 11'd0, 11'(TH - 1)};
`ifdef BBOX_MARGIN_EN
    x0 = (x0 - MG < 0) ? 0 : x0 - MG;
    y0 = (y0 - MG < 0) ? 0 : y0 - MG;
    x1 = (x1 + MG > TW - 1) ? TW - 1 : x1 + MG;
    y1 = (y1 + MG > TH - 1) ? TH - 1 : y1 + MG;
`endif
    return {1'b1, 11'(x0), 11'(x1), 11'(y0), 11'(y1)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < MEMN; i++) mem[i] = 8'hFF;
  endtask

  task automatic set_pix(input int x, input int y, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b);
    mem[(x * TH + y) * 3]     = r;
    mem[(x * TH + y) * 3 + 1] = g;
    mem[(x * TH + y) * 3 + 2] = b;
  endtask

  // one scan: pulse start, optionally re-pulse it mid-scan, sample address/outputs
  task automatic run_scan(input bit poke, output int cyc_out);
    int cyc;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 1;
    a1 = readAddr;
    while (done !== 1'b1 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3)  a3  = readAddr;
      if (cyc == 87) a87 = readAddr;
      if (cyc == 88) a88 = readAddr;
      if (cyc == 400) begin
        mid_res = cur_res();
        if (poke) start = 1'b1;
      end
      if (cyc == 401) start = 1'b0;
    end
    cyc_out = (done === 1'b1) ? cyc : -1;
  endtask

  task automatic scan_and_score(input string tag, input bit poke);
    run_scan(poke, lat);
    chk({tag, "_latency"}, 64'(lat), 64'(LAT));
    chk({tag, "_hold"}, 64'(mid_res), 64'(last_res));
    exp_res = exp_q.pop_front();
    chk({tag, "_box"}, 64'(cur_res()), 64'(exp_res));
    last_res = cur_res();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_box"}, 64'(cur_res()), 64'(exp_box(0, 0, 0, 0, 0)));
    chk({tag, "_addr"}, 64'(readAddr), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  initial begin
    clear_img();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_reset_outputs("reset");
    last_res = exp_box(0, 0, 0, 0, 0);

    // all-white frame, with a stray start mid-scan that must be ignored
    exp_q.push_back(exp_box(0, 0, 0, 0, 0));
    scan_and_score("white", 1'b1);
    chk("addr_c1", 64'(a1), 64'd0);
    chk("addr_c3", 64'(a3), 64'd1);
    chk("addr_read_p12", 64'(a87), 64'd37);
    chk("addr_capt_p12", 64'(a88), 64'd37);

    set_pix(7, 4, 8'd10, 8'd10, 8'd10);
    exp_q.push_back(exp_box(1, 7, 7, 4, 4));
    scan_and_score("single", 1'b0);

    clear_img();
    set_pix(5, 5, 8'd128, 8'd128, 8'd128);
    exp_q.push_back(exp_box(0, 0, 0, 0, 0));
    scan_and_score("thr384", 1'b0);

    set_pix(5, 5, 8'd128, 8'd128, 8'd127);
    exp_q.push_back(exp_box(1, 5, 5, 5, 5));
    scan_and_score("thr383", 1'b0);

    // rst and start together: rst wins, so the scan never begins
    @(negedge clk) begin rst = 1'b1; start = 1'b1; end
    @(negedge clk) begin rst = 1'b0; start = 1'b0; end
    check_reset_outputs("rst_start");
    repeat (10) @(negedge clk);
    chk("rst_start_idle", 64'(dbg_state), 64'd0);
    last_res = exp_box(0, 0, 0, 0, 0);

    clear_img();
    set_pix(2, 7, 8'd0, 8'd0, 8'd0);
    set_pix(9, 3, 8'd50, 8'd60, 8'd70);
    set_pix(5, 5, 8'd100, 8'd100, 8'd100);
    exp_q.push_back(exp_box(1, 2, 9, 3, 7));
    scan_and_score("multi", 1'b0);

    // rst mid-scan discards the partial scan and restores reset outputs
    clear_img();
    set_pix(8, 8, 8'd20, 8'd20, 8'd20);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (298) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_reset_outputs("midrst");
    repeat (5) @(negedge clk);
    last_res = exp_box(0, 0, 0, 0, 0);
    exp_q.push_back(exp_box(1, 8, 8, 8, 8));
    scan_and_score("after_rst", 1'b0);

    clear_img();
    set_pix(1, TH - 2, 8'd5, 8'd5, 8'd5);
    exp_q.push_back(exp_box(1, 1, 1, TH - 2, TH - 2));
    scan_and_score("edge", 1'b0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
